// File: rtl/fifo19_demux.sv
`default_nettype none
// fifo19_demux: steers each 19-bit packet to port 0 or port 1 from a masked compare of its header line.
// Optional FIFO19_DEMUX_STATS_EN adds per-port packet counters (pkt_count0/pkt_count1).

module fifo19_demux_short_fifo #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] datain,
  input  logic             src_rdy_i,
  output logic             dst_rdy_o,
  output logic [WIDTH-1:0] dataout,
  output logic             src_rdy_o,
  input  logic             dst_rdy_i
);
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign dst_rdy_o = (count != (AW+1)'(DEPTH));
  assign src_rdy_o = (count != '0);
  assign do_wr     = src_rdy_i & dst_rdy_o;
  assign do_rd     = src_rdy_o & dst_rdy_i;
  assign dataout   = mem[rd_ptr];

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= datain;
  end

  always_ff @(posedge clk) begin
    if (reset | clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module fifo19_demux #(
  parameter logic [15:0] MASK  = 16'h8000,
  parameter logic [15:0] MATCH = 16'h8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [18:0] data_i,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [18:0] data0_o,
  output logic        src0_rdy_o,
  input  logic        dst0_rdy_i,
  output logic [18:0] data1_o,
  output logic        src1_rdy_o,
  input  logic        dst1_rdy_i
`ifdef FIFO19_DEMUX_STATS_EN
  ,
  output logic [15:0] pkt_count0,
  output logic [15:0] pkt_count1
`endif
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA0 = 2'd1;
  localparam logic [1:0] DATA1 = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [18:0] int_data;
  logic        int_rdy;
  logic        int_pop;
  logic        wr0;
  logic        wr1;
  logic        buf0_in_rdy;
  logic        buf1_in_rdy;
  logic        eof;
  logic        route1;

  assign eof    = int_data[17];
  assign route1 = ((int_data[15:0] & MASK) == MATCH);

  fifo19_demux_short_fifo #(.WIDTH(19)) u_in_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .datain    (data_i),
    .src_rdy_i (src_rdy_i),
    .dst_rdy_o (dst_rdy_o),
    .dataout   (int_data),
    .src_rdy_o (int_rdy),
    .dst_rdy_i (int_pop)
  );

  fifo19_demux_short_fifo #(.WIDTH(19)) u_out0_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .datain    (int_data),
    .src_rdy_i (wr0),
    .dst_rdy_o (buf0_in_rdy),
    .dataout   (data0_o),
    .src_rdy_o (src0_rdy_o),
    .dst_rdy_i (dst0_rdy_i)
  );

  fifo19_demux_short_fifo #(.WIDTH(19)) u_out1_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .datain    (int_data),
    .src_rdy_i (wr1),
    .dst_rdy_o (buf1_in_rdy),
    .dataout   (data1_o),
    .src_rdy_o (src1_rdy_o),
    .dst_rdy_i (dst1_rdy_i)
  );

  always_ff @(posedge clk) begin
    if (reset | clear)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // The header is only inspected in IDLE; it is consumed later as the first DATAn line.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (int_rdy) state_nxt = route1 ? DATA1 : DATA0;
      DATA0:   if (int_rdy & buf0_in_rdy & eof) state_nxt = IDLE;
      DATA1:   if (int_rdy & buf1_in_rdy & eof) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr0     = 1'b0;
    wr1     = 1'b0;
    int_pop = 1'b0;
    case (state)
      DATA0: begin
        wr0     = int_rdy;
        int_pop = buf0_in_rdy;
      end
      DATA1: begin
        wr1     = int_rdy;
        int_pop = buf1_in_rdy;
      end
      default: ;
    endcase
  end

`ifdef FIFO19_DEMUX_STATS_EN
  logic cnt0_en;
  logic cnt1_en;

  // A write in a clear cycle is flushed with the buffer, so it is not counted.
  assign cnt0_en = wr0 & buf0_in_rdy & eof & ~clear;
  assign cnt1_en = wr1 & buf1_in_rdy & eof & ~clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count0 <= '0;
      pkt_count1 <= '0;
    end else begin
      if (cnt0_en)
        pkt_count0 <= pkt_count0 + 16'd1;
      if (cnt1_en)
        pkt_count1 <= pkt_count1 + 16'd1;
    end
  end
`endif
endmodule
`default_nettype wire
